// File: rtl/sa_tile_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sa_ctrl_pkg
// Shared definitions for the systolic-array tile sequencer:
//   - sa_state_t : controller state encoding
//   - SA_N / SA_CNT_W : default array dimension and phase counter width
//   - phase length helpers and derived default phase lengths
// ---------------------------------------------------------------------------
package sa_ctrl_pkg;

  localparam int SA_N     = 16;
  localparam int SA_CNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WLOAD   = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } sa_state_t;

  // Phase lengths in cycles for an n x n array.
  function automatic int wload_len(input int n);
    return n;
  endfunction

  function automatic int compute_len(input int n);
    return n;
  endfunction

  // The drain phase waits n-1 cycles for the skewed wavefront to reach the
  // output edge, then presents n result rows.
  function automatic int drain_len(input int n);
    return (2 * n) - 1;
  endfunction

  // The largest count ever reached is 2n-2, so 2n-1 must fit in cnt_w bits.
  function automatic bit cnt_w_ok(input int n, input int cnt_w);
    return ((2 * n) - 1) <= ((1 << cnt_w) - 1);
  endfunction

  function automatic logic is_busy_state(input sa_state_t s);
    return (s == ST_WLOAD) || (s == ST_COMPUTE) || (s == ST_DRAIN);
  endfunction

  localparam int SA_WLOAD_LEN   = SA_N;
  localparam int SA_COMPUTE_LEN = SA_N;
  localparam int SA_DRAIN_LEN   = (2 * SA_N) - 1;

endpackage

// File: rtl/sa_tile_ctrl_if.sv
// ---------------------------------------------------------------------------
// sa_tile_ctrl_if
// Host command / array control bundle of the tile sequencer.
//   start, wkeep, abort      : host -> controller commands
//   busy, done               : controller -> host status
//   w_shift_en, w_row        : weight preload controls to the array
//   a_valid, a_row           : activation stream controls
//   out_valid, out_row       : result drain controls
// Modports: master = host side (drives commands), slave = controller.
// ---------------------------------------------------------------------------
interface sa_tile_ctrl_if #(
  parameter int CNT_W = 5
);

  logic             start;
  logic             wkeep;
  logic             abort;
  logic             busy;
  logic             done;
  logic             w_shift_en;
  logic [CNT_W-1:0] w_row;
  logic             a_valid;
  logic [CNT_W-1:0] a_row;
  logic             out_valid;
  logic [CNT_W-1:0] out_row;

  modport master (
    output start, wkeep, abort,
    input  busy, done, w_shift_en, w_row, a_valid, a_row, out_valid, out_row
  );

  modport slave (
    input  start, wkeep, abort,
    output busy, done, w_shift_en, w_row, a_valid, a_row, out_valid, out_row
  );

endinterface

// File: rtl/sa_tile_ctrl_phase_counter.sv
// ---------------------------------------------------------------------------
// sa_phase_counter
// CNT_W-bit phase up-counter with synchronous clear and enable.
//   clk, rstn  : clock, asynchronous active-low reset
//   i_clr      : synchronous clear (wins over enable)
//   i_en       : count enable
//   o_cnt      : current count
//   o_cnt_nxt  : value the count takes at the next edge; lets the owner
//                register decoded outputs in step with the counter
// ---------------------------------------------------------------------------
module sa_phase_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_cnt_nxt
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Next-count selection: clear, increment or hold.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else if (i_en) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_cnt_nxt = w_cnt_nxt;

endmodule

// File: rtl/sa_tile_ctrl.sv
// ---------------------------------------------------------------------------
// sa_tile_ctrl
// Tile sequencer for the NxN systolic array. A start request runs weight
// preload (skipped with wkeep), activation streaming and result drain, then
// pulses done for one cycle. abort returns to IDLE from any state.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   bus         : sa_tile_ctrl_if.slave (commands, status, array controls)
//   busy_cycles : 16-bit saturating busy-cycle counter, present only when
//                 SA_TILE_CTRL_PERF_EN is defined
// All outputs are flops loaded from the next state / next count, so they
// line up with the state they describe and no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module sa_tile_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int N     = SA_N,
  parameter int CNT_W = SA_CNT_W
) (
  input  logic         clk,
  input  logic         rstn,
  sa_tile_ctrl_if.slave bus
`ifdef SA_TILE_CTRL_PERF_EN
  ,
  output logic [15:0]  busy_cycles
`endif
);

  if (!cnt_w_ok(N, CNT_W)) begin : g_cnt_w_check
    $fatal(1, "sa_tile_ctrl: CNT_W too narrow for 2N-1");
  end
  if ((N < 2) || (N > 16)) begin : g_n_check
    $fatal(1, "sa_tile_ctrl: N outside 2..16");
  end

  localparam logic [CNT_W-1:0] L_WLOAD_LAST   = CNT_W'(wload_len(N) - 1);
  localparam logic [CNT_W-1:0] L_COMPUTE_LAST = CNT_W'(compute_len(N) - 1);
  localparam logic [CNT_W-1:0] L_DRAIN_LAST   = CNT_W'(drain_len(N) - 1);
  // First drain count at which a finished result row leaves the array.
  localparam logic [CNT_W-1:0] L_OUT_BASE     = CNT_W'(N - 1);

  sa_state_t        r_state;
  sa_state_t        w_nxt_state;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_clr;
  logic             w_cnt_en;

  logic             w_nxt_busy;
  logic             w_nxt_done;
  logic             w_nxt_wse;
  logic [CNT_W-1:0] w_nxt_w_row;
  logic             w_nxt_av;
  logic [CNT_W-1:0] w_nxt_a_row;
  logic             w_nxt_ov;
  logic [CNT_W-1:0] w_nxt_out_row;

  logic             r_busy;
  logic             r_done;
  logic             r_wse;
  logic [CNT_W-1:0] r_w_row;
  logic             r_av;
  logic [CNT_W-1:0] r_a_row;
  logic             r_ov;
  logic [CNT_W-1:0] r_out_row;

  // Next-state decode; abort overrides everything, including a new start.
  always_comb begin
    w_nxt_state = r_state;
    if (bus.abort) begin
      w_nxt_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            if (bus.wkeep) begin
              w_nxt_state = ST_COMPUTE;
            end else begin
              w_nxt_state = ST_WLOAD;
            end
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end
        ST_WLOAD: begin
          if (w_cnt == L_WLOAD_LAST) begin
            w_nxt_state = ST_COMPUTE;
          end else begin
            w_nxt_state = ST_WLOAD;
          end
        end
        ST_COMPUTE: begin
          if (w_cnt == L_COMPUTE_LAST) begin
            w_nxt_state = ST_DRAIN;
          end else begin
            w_nxt_state = ST_COMPUTE;
          end
        end
        ST_DRAIN: begin
          if (w_cnt == L_DRAIN_LAST) begin
            w_nxt_state = ST_DONE;
          end else begin
            w_nxt_state = ST_DRAIN;
          end
        end
        default: begin
          w_nxt_state = ST_IDLE;
        end
      endcase
    end
  end

  // Counter is held at zero outside the busy phases and cleared on every
  // transition, so each phase starts counting from 0.
  assign w_cnt_clr = (w_nxt_state != r_state) || !is_busy_state(r_state);
  assign w_cnt_en  = is_busy_state(r_state);

  sa_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk       (clk),
    .rstn      (rstn),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .o_cnt     (w_cnt),
    .o_cnt_nxt (w_cnt_nxt)
  );

  // Output decode from next state and next count; indices are forced to 0
  // whenever their strobe is low.
  always_comb begin
    w_nxt_busy = is_busy_state(w_nxt_state);
    w_nxt_done = (w_nxt_state == ST_DONE);
    w_nxt_wse  = (w_nxt_state == ST_WLOAD);
    w_nxt_av   = (w_nxt_state == ST_COMPUTE);
    w_nxt_ov   = (w_nxt_state == ST_DRAIN) && (w_cnt_nxt >= L_OUT_BASE);
    if (w_nxt_wse) begin
      w_nxt_w_row = w_cnt_nxt;
    end else begin
      w_nxt_w_row = {CNT_W{1'b0}};
    end
    if (w_nxt_av) begin
      w_nxt_a_row = w_cnt_nxt;
    end else begin
      w_nxt_a_row = {CNT_W{1'b0}};
    end
    if (w_nxt_ov) begin
      w_nxt_out_row = w_cnt_nxt - L_OUT_BASE;
    end else begin
      w_nxt_out_row = {CNT_W{1'b0}};
    end
  end

  // Controller FSM: state register plus registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wse     <= 1'b0;
      r_w_row   <= {CNT_W{1'b0}};
      r_av      <= 1'b0;
      r_a_row   <= {CNT_W{1'b0}};
      r_ov      <= 1'b0;
      r_out_row <= {CNT_W{1'b0}};
    end else begin
      r_state   <= w_nxt_state;
      r_busy    <= w_nxt_busy;
      r_done    <= w_nxt_done;
      r_wse     <= w_nxt_wse;
      r_w_row   <= w_nxt_w_row;
      r_av      <= w_nxt_av;
      r_a_row   <= w_nxt_a_row;
      r_ov      <= w_nxt_ov;
      r_out_row <= w_nxt_out_row;
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.w_shift_en = r_wse;
  assign bus.w_row      = r_w_row;
  assign bus.a_valid    = r_av;
  assign bus.a_row      = r_a_row;
  assign bus.out_valid  = r_ov;
  assign bus.out_row    = r_out_row;

`ifdef SA_TILE_CTRL_PERF_EN
  logic [15:0] r_busy_cycles;

  // Busy-cycle counter: counts cycles with busy high, saturates, reset-only clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy_cycles <= 16'd0;
    end else if (r_busy && (r_busy_cycles != 16'hFFFF)) begin
      r_busy_cycles <= r_busy_cycles + 16'd1;
    end else begin
      r_busy_cycles <= r_busy_cycles;
    end
  end

  assign busy_cycles = r_busy_cycles;
`endif

endmodule

// File: tb/tb_sa_tile_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sa_tile_ctrl
// Self-checking bench for sa_tile_ctrl (N=16). Every cycle the DUT outputs
// are compared against a scoreboard of expected per-cycle output vectors,
// which are pushed when a start is accepted, computed from the phase timing
// (start in cycle t -> WLOAD t+1..t+N, ...). A table of scenarios also checks
// per-run event totals. Hand-written sequences cover async reset mid-tile
// and the optional busy-cycle counter.
// ---------------------------------------------------------------------------
module tb_sa_tile_ctrl;

  localparam int N  = 16;
  localparam int CW = 5;

  typedef logic [19:0] ovec_t;

  typedef struct {
    int    cyc;
    ovec_t v;
  } sb_t;

  typedef struct {
    logic wkeep;
    int   mode;        // 0: start at cycle 0; 1: held high; 2: pulses 0,5,40
    int   abort_cyc;   // -1: none
    int   len;
    int   e_done_n;
    int   e_first_done;
    int   e_last_done;
    int   e_busy_n;
    int   e_wse_n;
    int   e_av_n;
  } row_t;

  logic clk;
  logic rstn;
  sa_tile_ctrl_if #(.CNT_W(CW)) bus ();
`ifdef SA_TILE_CTRL_PERF_EN
  logic [15:0] busy_cycles;
`endif

  sa_tile_ctrl #(.N(N), .CNT_W(CW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef SA_TILE_CTRL_PERF_EN
    ,
    .busy_cycles (busy_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  n_vec;
  int  n_err;
  int  cyc;
  int  m_done;
  sb_t sb_q[$];
  int  st_done_n, st_first_done, st_last_done, st_busy_n, st_wse_n, st_av_n;

  function automatic ovec_t dut_vec();
    return {bus.busy, bus.done, bus.w_shift_en, bus.w_row,
            bus.a_valid, bus.a_row, bus.out_valid, bus.out_row};
  endfunction

  // Expected outputs 'rel' cycles after an accepted start (spec timing).
  function automatic ovec_t exp_at(input int rel, input logic wk);
    int r;
    logic b, d, ws, av, ov;
    logic [CW-1:0] wr, ar, orw;
    r   = wk ? rel + N : rel;
    b   = (r >= 1) && (r <= 4*N - 1);
    d   = (r == 4*N);
    ws  = (r >= 1) && (r <= N);
    av  = (r >= N + 1) && (r <= 2*N);
    ov  = (r >= 3*N) && (r <= 4*N - 1);
    wr  = ws ? CW'(r - 1) : 5'd0;
    ar  = av ? CW'(r - N - 1) : 5'd0;
    orw = ov ? CW'(r - 3*N) : 5'd0;
    return {b, d, ws, wr, av, ar, ov, orw};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input ovec_t act, input ovec_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Compare this cycle's outputs with the scoreboard and tally events.
  task automatic check_now();
    ovec_t e;
    e = 20'd0;
    if ((sb_q.size() > 0) && (sb_q[0].cyc == cyc)) begin
      e = sb_q[0].v;
      void'(sb_q.pop_front());
    end
    chkv("cycle", dut_vec(), e);
    if (bus.done === 1'b1) begin
      st_done_n++;
      if (st_first_done < 0) st_first_done = cyc;
      st_last_done = cyc;
    end
    if (bus.busy === 1'b1) st_busy_n++;
    if (bus.w_shift_en === 1'b1) st_wse_n++;
    if (bus.a_valid === 1'b1) st_av_n++;
  endtask

  // Check cycle 'cyc', drive its inputs, update the model, advance a cycle.
  task automatic step(input logic s, input logic wk, input logic ab);
    int len;
    check_now();
    bus.start = s;
    bus.wkeep = wk;
    bus.abort = ab;
    if (ab) begin
      while ((sb_q.size() > 0) && (sb_q[$].cyc > cyc)) void'(sb_q.pop_back());
      m_done = cyc;
    end else if (s && (cyc >= m_done)) begin
      len = wk ? 3*N : 4*N;
      for (int k = 1; k <= len; k++) sb_q.push_back('{cyc + k, exp_at(k, wk)});
      m_done = cyc + len;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_stats();
    st_done_n = 0; st_first_done = -1; st_last_done = -1;
    st_busy_n = 0; st_wse_n = 0; st_av_n = 0;
  endtask

  task automatic do_reset();
    bus.start = 1'b0;
    bus.wkeep = 1'b0;
    bus.abort = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chkv("reset", dut_vec(), 20'd0);
`ifdef SA_TILE_CTRL_PERF_EN
    chk("reset_busy_cycles", int'(busy_cycles), 0);
`endif
    rstn = 1'b1;
    sb_q.delete();
    m_done = -1;
    cyc = 0;
    clear_stats();
  endtask

  row_t tbl[7];

  initial begin
    logic s;
    n_vec = 0;
    n_err = 0;
    rstn  = 1'b0;
    bus.start = 1'b0;
    bus.wkeep = 1'b0;
    bus.abort = 1'b0;

    tbl[0] = '{1'b0, 0, -1,  70, 1, 64,  64,  63, 16, 16};
    tbl[1] = '{1'b1, 0, -1,  55, 1, 48,  48,  47,  0, 16};
    tbl[2] = '{1'b0, 1, -1, 129, 2, 64, 128, 126, 32, 32};
    tbl[3] = '{1'b0, 0, 20,  70, 0, -1,  -1,  20, 16,  4};
    tbl[4] = '{1'b0, 0,  0,  10, 0, -1,  -1,   0,  0,  0};
    tbl[5] = '{1'b0, 2, -1,  70, 1, 64,  64,  63, 16, 16};
    tbl[6] = '{1'b1, 0, 10,  40, 0, -1,  -1,  10,  0, 10};

    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      do_reset();
      for (int c = 0; c < tbl[i].len; c++) begin
        case (tbl[i].mode)
          0:       s = (c == 0);
          1:       s = 1'b1;
          default: s = (c == 0) || (c == 5) || (c == 40);
        endcase
        step(s, tbl[i].wkeep, c == tbl[i].abort_cyc);
      end
      chk($sformatf("row%0d_done_n", i), st_done_n, tbl[i].e_done_n);
      chk($sformatf("row%0d_first_done", i), st_first_done, tbl[i].e_first_done);
      chk($sformatf("row%0d_last_done", i), st_last_done, tbl[i].e_last_done);
      chk($sformatf("row%0d_busy_n", i), st_busy_n, tbl[i].e_busy_n);
      chk($sformatf("row%0d_wse_n", i), st_wse_n, tbl[i].e_wse_n);
      chk($sformatf("row%0d_av_n", i), st_av_n, tbl[i].e_av_n);
    end

    // Reset asserted mid-tile in cycle 50: outputs clear at once, no done.
    do_reset();
    for (int c = 0; c < 50; c++) step(c == 0, 1'b0, 1'b0);
    check_now();
    rstn = 1'b0;
    #1;
    chkv("async_reset", dut_vec(), 20'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    sb_q.delete();
    m_done = -1;
    cyc = 0;
    clear_stats();
    for (int c = 0; c < 30; c++) step(1'b0, 1'b0, 1'b0);
    chk("post_reset_done_n", st_done_n, 0);

`ifdef SA_TILE_CTRL_PERF_EN
    // One full tile gives 63 busy cycles; then saturate under held start.
    do_reset();
    for (int c = 0; c < 66; c++) step(c == 0, 1'b0, 1'b0);
    chk("busy_cycles_one_tile", int'(busy_cycles), 63);
    bus.start = 1'b1;
    repeat (66700) @(posedge clk);
    @(negedge clk);
    chk("busy_cycles_saturate", int'(busy_cycles), 65535);
    bus.start = 1'b0;
    do_reset();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sa_tile_ctrl.md
# sa_tile_ctrl

Sequencing controller for the 16x16 systolic array tile. On a `start` request it runs one tile computation as three back-to-back phases: weight preload, activation streaming and result drain. During each phase it drives the array's shift, valid and row-index controls from a single phase counter. It sits between the host/command interface and the array datapath, and reports `busy` and `done` to the host.

## Interface
- `N`, 16: array dimension (rows = columns); legal range 2..16.
- `CNT_W`, 5: phase counter width; must satisfy 2N-1 <= 2^CNT_W - 1 (elaboration-time check, fatal on violation).
- `clk` input 1: single clock, rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `start` input 1: begin a tile; sampled only in IDLE or DONE.
- `wkeep` input 1: sampled with `start`; 1 = reuse resident weights and skip preload.
- `abort` input 1: synchronous abort, valid in any state.
- `busy` output 1: high in WLOAD, COMPUTE and DRAIN.
- `done` output 1: one-cycle pulse in DONE.
- `w_shift_en` output 1: weight shift enable to the array.
- `w_row` output CNT_W: weight row being loaded.
- `a_valid` output 1: activation stream valid.
- `a_row` output CNT_W: activation vector index.
- `out_valid` output 1: result row valid at the array output.
- `out_row` output CNT_W: result row index.
- `busy_cycles` output 16: only present with SA_TILE_CTRL_PERF_EN (see Configuration).

## Operation
- FSM states: IDLE, WLOAD, COMPUTE, DRAIN, DONE. The phase counter is cleared on every state change and increments by 1 each cycle inside a state.
- IDLE/DONE with `start`=1:
  - `wkeep`=0 -> WLOAD.
  - `wkeep`=1 -> COMPUTE.
- IDLE/DONE with `start`=0 -> IDLE.
- WLOAD: lasts N cycles; `w_shift_en`=1, `w_row`=count (0..N-1). Exits to COMPUTE at count N-1.
- COMPUTE: lasts N cycles; `a_valid`=1, `a_row`=count. Exits to DRAIN at count N-1.
- DRAIN: lasts 2N-1 cycles; `out_valid`=1 when count >= N-1, with `out_row`=count-(N-1) (0..N-1). Exits to DONE at count 2N-2.
- DONE: lasts 1 cycle; `done`=1 and `busy`=0. A back-to-back `start` is accepted in this cycle.
- Row/index outputs are 0 whenever their qualifying strobe is low.
- `abort`=1 in any state -> IDLE next cycle; `done` is not pulsed.
- `abort` and `start` together: `abort` wins and the FSM stays in IDLE.
- `start` while busy is ignored; no queuing.
- Counter never wraps: each exit happens at or below 2N-2.

## Timing
- Reset values:
  - state = IDLE, counter = 0.
  - All outputs 0, including `busy_cycles`.
- All outputs are registered or decoded from registered state/counter only; there is no combinational path from any input to any output.
- `start` high in cycle t, `wkeep`=0:
  - WLOAD in cycles t+1..t+N.
  - COMPUTE in cycles t+N+1..t+2N.
  - DRAIN in cycles t+2N+1..t+4N-1; `out_valid` in cycles t+3N..t+4N-1.
  - `done` in cycle t+4N (t+64 for N=16).
- With `wkeep`=1 every phase moves N cycles earlier; `done` in cycle t+3N.
- Reset asserted mid-tile: returns to reset values immediately; no `done`.

## Configuration
- `SA_TILE_CTRL_PERF_EN` defined:
  - `busy_cycles` port exists.
  - It is a 16-bit counter that increments every cycle `busy`=1 and saturates at 0xFFFF.
  - It clears on reset only.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `sa_ctrl_pkg`:
  - state enum (IDLE, WLOAD, COMPUTE, DRAIN, DONE).
  - default `SA_N`=16 and `SA_CNT_W`=5.
  - derived constants for phase lengths: N, N, 2N-1.
- One sub-module, `sa_phase_counter`: CNT_W-bit up-counter with async active-low reset, synchronous clear and enable. The FSM drives clear on every state transition.

## Test plan
- Reset, then `start`=1/`wkeep`=0 at cycle 0:
  - `w_shift_en` in cycles 1..16 with `w_row` 0..15.
  - `a_valid` in cycles 17..32.
  - `out_valid` in cycles 48..63 with `out_row` 0..15.
  - `done` in cycle 64; `busy` high in cycles 1..63.
- `start` with `wkeep`=1 -> no `w_shift_en`; `a_valid` in cycles 1..16; `done` in cycle 48.
- `start` held high continuously -> second tile's WLOAD begins in cycle 65; `done` pulses in cycles 64 and 128.
- `abort` in cycle 20 (COMPUTE) -> IDLE from cycle 21; all strobes 0; no `done`. `start`+`abort` together in IDLE -> stays IDLE.
- `start` pulsed in cycles 5 and 40 while busy -> ignored; `done` still only in cycle 64.
- `rstn` asserted in cycle 50 -> all outputs 0 immediately. With PERF_EN, `busy_cycles`=63 after one full tile, and it saturates at 0xFFFF under continuous `start`.
